// File: rtl/fx2_slave_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// fx2_slave_fifo_ctrl
//
// Purpose:
//   Master side of a Cypress FX2 slave-FIFO link. Each transaction does four
//   things in order:
//     1. reads RX_WORDS words from EP2 into a local input buffer (MEM)
//     2. hands MEM to an external processor (proc_start / proc_done)
//     3. collects TX_WORDS result words into a result buffer (RES)
//     4. writes RES to EP6
//   If the processor does not answer within PROC_TIMEOUT cycles, the sticky
//   err flag is set and the transaction is dropped without touching EP6.
//
// Optional feature:
//   FX2_PKTEND_EN -- when defined, COMMIT pulses PKTEND low for one cycle to
//   flush a short EP6 packet, and waits in COMMIT while EP6 is full. When it
//   is undefined, PKTEND stays high and COMMIT lasts exactly one cycle.
//
// Ports:
//   CLKOUT      sole clock (FX2 CLKOUT)
//   rst         synchronous active-high reset
//   FLAGA       EP2 empty flag, active low (1 = data available)
//   FLAGD       EP6 full flag, active low (1 = space available)
//   SLRD/SLWR   FIFO read / write strobes, active low
//   SLOE        FX2 output enable, active low
//   PKTEND      packet-end strobe, active low
//   FIFOADR     endpoint select (00 = EP2, 10 = EP6)
//   IFCLK       interface clock back to the FX2, ~CLKOUT
//   FDATA       bidirectional FX2 data bus
//   proc_start  one-cycle pulse on the first PROC cycle
//   proc_done   processor completion
//   buf_raddr   MEM read address; buf_rdata follows one cycle later
//   res_we/res_waddr/res_wdata  RES write port, honoured only in PROC
//   cState      current FSM state
//   RCount      words read this transaction
//   WCount      words written this transaction
//   err         sticky processor-timeout flag
//
// Handshake: a FIFO word moves on every rising CLKOUT edge where the strobe
// (SLRD or SLWR) is low. The strobes are combinational from the FX2 flags, so
// a flag going inactive stalls the transfer in that same cycle.
// ---------------------------------------------------------------------------
module fx2_slave_fifo_ctrl #(
  parameter int DW           = 16,
  parameter int RX_WORDS     = 18,
  parameter int TX_WORDS     = 4,
  parameter int MEM_DEPTH    = 32,
  parameter int PROC_TIMEOUT = 1024
) (
  input  logic                         CLKOUT,
  input  logic                         rst,
  input  logic                         FLAGA,
  input  logic                         FLAGD,
  output logic                         SLRD,
  output logic                         SLWR,
  output logic                         SLOE,
  output logic                         PKTEND,
  output logic [1:0]                   FIFOADR,
  output logic                         IFCLK,
  inout  wire  [DW-1:0]                FDATA,
  output logic                         proc_start,
  input  logic                         proc_done,
  input  logic [$clog2(MEM_DEPTH)-1:0] buf_raddr,
  output logic [DW-1:0]                buf_rdata,
  input  logic                         res_we,
  input  logic [3:0]                   res_waddr,
  input  logic [DW-1:0]                res_wdata,
  output logic [2:0]                   cState,
  output logic [15:0]                  RCount,
  output logic [15:0]                  WCount,
  output logic                         err
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam int TW = $clog2(PROC_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RX       = 3'd1,
    S_PROC     = 3'd2,
    S_TX_SETUP = 3'd3,
    S_TX       = 3'd4,
    S_COMMIT   = 3'd5
  } state_t;

  state_t        state;
  state_t        next_state;
  logic          rd_fire;
  logic          wr_fire;
  logic          tmo_hit;
  logic          fdata_oe;
  logic [TW-1:0] tmo_cnt;

  logic [DW-1:0] mem [MEM_DEPTH];
  logic [DW-1:0] res [16];

  assign cState = state;
  assign IFCLK  = ~CLKOUT;
  assign FDATA  = fdata_oe ? res[WCount[3:0]] : {DW{1'bz}};

  // State register
  always_ff @(posedge CLKOUT) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state and FX2 strobes
  always_comb begin
    next_state = state;
    SLRD       = 1'b1;
    SLWR       = 1'b1;
    SLOE       = 1'b1;
    PKTEND     = 1'b1;
    FIFOADR    = 2'b00;
    fdata_oe   = 1'b0;
    rd_fire    = 1'b0;
    wr_fire    = 1'b0;
    tmo_hit    = 1'b0;
    case (state)
      S_IDLE: begin
        next_state = S_RX;
      end
      S_RX: begin
        SLOE = 1'b0;
        if (FLAGA && (RCount < 16'(RX_WORDS))) begin
          SLRD    = 1'b0;
          rd_fire = 1'b1;
        end
        if (rd_fire && (RCount == 16'(RX_WORDS - 1))) begin
          next_state = S_PROC;
        end
      end
      S_PROC: begin
        // proc_done wins over a timeout expiring in the same cycle
        if (proc_done) begin
          next_state = S_TX_SETUP;
        end else if (tmo_cnt == TW'(PROC_TIMEOUT - 1)) begin
          tmo_hit    = 1'b1;
          next_state = S_IDLE;
        end
      end
      S_TX_SETUP: begin
        // One bus-turnaround cycle: FX2 has released FDATA, we do not drive yet
        FIFOADR    = 2'b10;
        next_state = S_TX;
      end
      S_TX: begin
        FIFOADR  = 2'b10;
        fdata_oe = 1'b1;
        if (FLAGD && (WCount < 16'(TX_WORDS))) begin
          SLWR    = 1'b0;
          wr_fire = 1'b1;
        end
        if (wr_fire && (WCount == 16'(TX_WORDS - 1))) begin
          next_state = S_COMMIT;
        end
      end
      S_COMMIT: begin
        FIFOADR = 2'b10;
`ifdef FX2_PKTEND_EN
        if (FLAGD) begin
          PKTEND     = 1'b0;
          next_state = S_IDLE;
        end
`else
        next_state = S_IDLE;
`endif
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // Counters, processor handshake and error flag
  always_ff @(posedge CLKOUT) begin
    if (rst) begin
      RCount     <= '0;
      WCount     <= '0;
      err        <= 1'b0;
      proc_start <= 1'b0;
      tmo_cnt    <= '0;
    end else begin
      // Entering IDLE (from COMMIT or a timeout) clears both counters
      if (next_state == S_IDLE) begin
        RCount <= '0;
        WCount <= '0;
      end else begin
        if (rd_fire) RCount <= RCount + 16'd1;
        if (wr_fire) WCount <= WCount + 16'd1;
      end
      err        <= err | tmo_hit;
      proc_start <= (state == S_RX) && (next_state == S_PROC);
      tmo_cnt    <= (state == S_PROC) ? tmo_cnt + TW'(1) : '0;
    end
  end

  // Buffers: contents are never reset
  always_ff @(posedge CLKOUT) begin
    if (rd_fire && !rst) begin
      mem[RCount[AW-1:0]] <= FDATA;
    end
    buf_rdata <= mem[buf_raddr];
  end

  always_ff @(posedge CLKOUT) begin
    if (!rst && (state == S_PROC) && res_we &&
        ({1'b0, res_waddr} < 5'(TX_WORDS))) begin
      res[res_waddr] <= res_wdata;
    end
  end

endmodule

// File: tb/tb_fx2_slave_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fx2_slave_fifo_ctrl
//
// Directed bench for fx2_slave_fifo_ctrl (PROC_TIMEOUT = 8, other parameters
// at their defaults). The bench models the FX2 side of FDATA: it drives the
// bus while the controller should be tri-stated, so reading back its own
// pattern shows the controller is not driving.
// ---------------------------------------------------------------------------
module tb_fx2_slave_fifo_ctrl;

  logic        CLKOUT;
  logic        rst;
  logic        FLAGA;
  logic        FLAGD;
  logic        SLRD;
  logic        SLWR;
  logic        SLOE;
  logic        PKTEND;
  logic [1:0]  FIFOADR;
  logic        IFCLK;
  wire  [15:0] FDATA;
  logic        proc_start;
  logic        proc_done;
  logic [4:0]  buf_raddr;
  logic [15:0] buf_rdata;
  logic        res_we;
  logic [3:0]  res_waddr;
  logic [15:0] res_wdata;
  logic [2:0]  cState;
  logic [15:0] RCount;
  logic [15:0] WCount;
  logic        err;

  logic        tb_oe;
  logic [15:0] tb_data;

  int vec_cnt   = 0;
  int mis_cnt   = 0;
  int slrd_lows = 0;
  int slwr_lows = 0;

  assign FDATA = tb_oe ? tb_data : 16'hzzzz;

`ifdef FX2_PKTEND_EN
  localparam logic EXP_PKTEND_COMMIT = 1'b0;
`else
  localparam logic EXP_PKTEND_COMMIT = 1'b1;
`endif

  fx2_slave_fifo_ctrl #(
    .DW(16), .RX_WORDS(18), .TX_WORDS(4), .MEM_DEPTH(32), .PROC_TIMEOUT(8)
  ) dut (
    .CLKOUT(CLKOUT), .rst(rst), .FLAGA(FLAGA), .FLAGD(FLAGD),
    .SLRD(SLRD), .SLWR(SLWR), .SLOE(SLOE), .PKTEND(PKTEND),
    .FIFOADR(FIFOADR), .IFCLK(IFCLK), .FDATA(FDATA),
    .proc_start(proc_start), .proc_done(proc_done),
    .buf_raddr(buf_raddr), .buf_rdata(buf_rdata),
    .res_we(res_we), .res_waddr(res_waddr), .res_wdata(res_wdata),
    .cState(cState), .RCount(RCount), .WCount(WCount), .err(err)
  );

  // Clock / reset block
  initial begin
    CLKOUT = 1'b0;
    forever #5 CLKOUT = ~CLKOUT;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Strobe monitor, sampled mid-cycle
  always @(negedge CLKOUT) begin
    if (!rst) begin
      if (!SLRD) slrd_lows++;
      if (!SLWR) slwr_lows++;
      vec_cnt++;
      assert (!(SLRD == 1'b0 && SLWR == 1'b0))
      else begin
        mis_cnt++;
        $error("FAIL strobe_overlap: got SLRD=%b SLWR=%b, required not both 0", SLRD, SLWR);
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge CLKOUT);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp)
    else begin
      mis_cnt++;
      $error("FAIL %s: got %0h, required %0h", tag, obs, exp);
    end
  endtask

  int rd0;
  int wr0;
  int k;

  initial begin
    rst = 1'b1; FLAGA = 1'b0; FLAGD = 1'b1; proc_done = 1'b0;
    res_we = 1'b0; res_waddr = '0; res_wdata = '0; buf_raddr = '0;
    tb_oe = 1'b1; tb_data = 16'h5A5A;

    // ---- reset state
    repeat (3) tick();
    #1;
    chk("rst_state", cState, 0);
    chk("rst_rcount", RCount, 0);
    chk("rst_wcount", WCount, 0);
    chk("rst_err", err, 0);
    chk("rst_strobes", {SLRD, SLWR, SLOE, PKTEND}, 4'b1111);
    chk("rst_fifoadr", FIFOADR, 0);
    chk("rst_proc_start", proc_start, 0);
    chk("rst_fdata_z", FDATA, 16'h5A5A);

    rst = 1'b0;
    tick(); #1;
    chk("idle_to_rx", cState, 1);

    // ---- RX stalled on empty EP2
    FLAGA = 1'b0; #1;
    chk("rx_stall_slrd", SLRD, 1);
    chk("rx_sloe", SLOE, 0);
    chk("rx_fifoadr", FIFOADR, 0);
    tick(); tick(); #1;
    chk("rx_stall_rcount", RCount, 0);
    chk("rx_stall_state", cState, 1);

    // ---- 18 back-to-back reads
    rd0 = slrd_lows;
    for (int i = 0; i < 18; i++) begin
      FLAGA = 1'b1; tb_data = 16'(i + 1); #1;
      chk("rx_slrd_low", SLRD, 0);
      tick();
    end
    FLAGA = 1'b0;
    // PROC cycle 0
    res_we = 1'b1; res_waddr = 4'd0; res_wdata = 16'h00A0; #1;
    chk("proc_state", cState, 2);
    chk("proc_rcount", RCount, 18);
    chk("proc_start_pulse", proc_start, 1);
    chk("rx_read_count", slrd_lows - rd0, 18);
    tick();
    res_waddr = 4'd1; res_wdata = 16'h00A1; #1;
    chk("proc_start_once", proc_start, 0);
    tick();
    res_waddr = 4'd2; res_wdata = 16'h00A2; tick();
    res_waddr = 4'd3; res_wdata = 16'h00A3; tick();
    res_we = 1'b0; proc_done = 1'b1; tick();

    // ---- TX_SETUP; a RES write here must be ignored
    proc_done = 1'b0; res_we = 1'b1; res_waddr = 4'd0; res_wdata = 16'hFFFF;
    tb_data = 16'h5A5A; #1;
    chk("txs_state", cState, 3);
    chk("txs_fifoadr", FIFOADR, 2);
    chk("txs_strobes", {SLRD, SLWR, SLOE}, 3'b111);
    chk("txs_fdata_z", FDATA, 16'h5A5A);
    tb_oe = 1'b0; FLAGD = 1'b0;
    tick();

    // ---- TX stalled on full EP6; read MEM back meanwhile
    res_we = 1'b0; #1;
    chk("tx_state", cState, 4);
    chk("tx_stall_slwr", SLWR, 1);
    chk("tx_fdata0", FDATA, 16'h00A0);
    chk("tx_fifoadr", FIFOADR, 2);
    wr0 = slwr_lows;
    for (int i = 0; i < 18; i++) begin
      buf_raddr = 5'(i);
      tick(); #1;
      chk("mem_readback", buf_rdata, 32'(i + 1));
      chk("tx_stall_hold", SLWR, 1);
    end

    // ---- TX with a 5-cycle stall after the 2nd word
    FLAGD = 1'b1; #1;
    chk("tx_w0_slwr", SLWR, 0);
    chk("tx_w0_data", FDATA, 16'h00A0);
    tick(); #1;
    chk("tx_w1_wcount", WCount, 1);
    chk("tx_w1_data", FDATA, 16'h00A1);
    tick();
    FLAGD = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("tx_full_slwr", SLWR, 1);
      chk("tx_full_hold", FDATA, 16'h00A2);
      chk("tx_full_wcount", WCount, 2);
      tick();
    end
    FLAGD = 1'b1; #1;
    chk("tx_w2_slwr", SLWR, 0);
    chk("tx_w2_data", FDATA, 16'h00A2);
    tick(); #1;
    chk("tx_w3_data", FDATA, 16'h00A3);
    tick();

    // ---- COMMIT
    tb_oe = 1'b1; tb_data = 16'h5A5A; #1;
    chk("commit_state", cState, 5);
    chk("commit_wcount", WCount, 4);
    chk("commit_pktend", PKTEND, EXP_PKTEND_COMMIT);
    chk("commit_fdata_z", FDATA, 16'h5A5A);
    chk("tx_write_count", slwr_lows - wr0, 4);
    tick(); #1;
    chk("commit_to_idle", cState, 0);
    chk("idle_rcount", RCount, 0);
    chk("idle_wcount", WCount, 0);
    chk("idle_pktend", PKTEND, 1);
    tick(); #1;
    chk("idle_to_rx2", cState, 1);

    // ---- RX with FLAGA toggling every cycle
    rd0 = slrd_lows;
    wr0 = slwr_lows;
    k = 0;
    for (int c = 0; c < 36; c++) begin
      FLAGA = (c % 2 == 1);
      tb_data = 16'h0100 + 16'(k);
      #1;
      chk("toggle_slrd", SLRD, !FLAGA);
      if (FLAGA) k++;
      tick();
    end
    FLAGA = 1'b0; #1;
    chk("toggle_state", cState, 2);
    chk("toggle_rcount", RCount, 18);
    chk("toggle_reads", slrd_lows - rd0, 18);

    // ---- processor timeout
    for (int j = 1; j < 8; j++) begin
      tick(); #1;
      chk("tmo_in_proc", cState, 2);
      chk("tmo_err_low", err, 0);
    end
    tick(); #1;
    chk("tmo_to_idle", cState, 0);
    chk("tmo_err_set", err, 1);
    chk("tmo_rcount", RCount, 0);
    tick(); #1;
    chk("tmo_rx", cState, 1);
    chk("tmo_err_sticky", err, 1);
    chk("tmo_no_writes", slwr_lows - wr0, 0);
    for (int i = 0; i < 18; i++) begin
      buf_raddr = 5'(i);
      tick(); #1;
      chk("toggle_mem", buf_rdata, 32'(16'h0100 + 16'(i)));
    end

    // ---- reset in the middle of RX
    FLAGA = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tb_data = 16'h0200 + 16'(i);
      tick();
    end
    #1;
    chk("mid_rx_rcount", RCount, 7);
    rst = 1'b1;
    tick(); #1;
    chk("mrst_state", cState, 0);
    chk("mrst_counts", {RCount, WCount}, 0);
    chk("mrst_err", err, 0);
    chk("mrst_strobes", {SLRD, SLWR, SLOE, PKTEND}, 4'b1111);
    chk("mrst_fifoadr", FIFOADR, 0);
    chk("mrst_proc_start", proc_start, 0);
    chk("mrst_fdata_z", FDATA, tb_data);
    rst = 1'b0;
    tick(); #1;
    chk("mrst_to_rx", cState, 1);

    // ---- proc_done on the last PROC cycle counts as done; RES persists
    for (int i = 0; i < 18; i++) begin
      tb_data = 16'h0300 + 16'(i);
      tick();
    end
    FLAGA = 1'b0; #1;
    chk("edge_proc", cState, 2);
    for (int j = 1; j < 8; j++) tick();
    proc_done = 1'b1; #1;
    chk("edge_last_proc", cState, 2);
    tick(); #1;
    chk("edge_done_wins", cState, 3);
    chk("edge_no_err", err, 0);
    proc_done = 1'b0; tb_oe = 1'b0;
    tick(); #1;
    chk("res_persist", FDATA, 16'h00A0);
    repeat (4) tick();
    #1;
    chk("edge_commit", cState, 5);
    tb_oe = 1'b1;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
    $finish;
  end

endmodule

// File: doc/fx2_slave_fifo_ctrl.md
FX2_SLAVE_FIFO_CTRL -- requirements
Module: fx2_slave_fifo_ctrl

Interface
REQ-001 SHALL have parameter DW, default 16: FDATA/buffer word width.
REQ-002 SHALL have parameter RX_WORDS, default 18: words read from EP2 per transaction, 1..MEM_DEPTH.
REQ-003 SHALL have parameter TX_WORDS, default 4: result words written to EP6 per transaction, 1..16.
REQ-004 SHALL have parameter MEM_DEPTH, default 32: input buffer depth, power of two.
REQ-005 SHALL have parameter PROC_TIMEOUT, default 1024: max PROC-state cycles before abort.
REQ-006 SHALL have ports: CLKOUT in 1, sole clock; rst in 1, synchronous active-high reset.
REQ-007 SHALL have ports: FLAGA in 1, EP2 empty, active-low; FLAGD in 1, EP6 full, active-low.
REQ-008 SHALL have ports: SLRD, SLWR, SLOE, PKTEND out 1 each, active-low strobes; FIFOADR out 2; IFCLK out 1, equal to ~CLKOUT.
REQ-009 SHALL have port FDATA inout DW, FX2 data bus.
REQ-010 SHALL have ports: proc_start out 1; proc_done in 1; buf_raddr in log2(MEM_DEPTH); buf_rdata out DW.
REQ-011 SHALL have ports: res_we in 1; res_waddr in 4; res_wdata in DW.
REQ-012 SHALL have ports: cState out 3; RCount out 16; WCount out 16; err out 1 (sticky timeout flag).

Function
REQ-013 SHALL implement states IDLE=0, RX=1, PROC=2, TX_SETUP=3, TX=4, COMMIT=5; cState equals the current state.
REQ-014 SHALL transition IDLE->RX unconditionally, one cycle after reset release.
REQ-015 In RX: SLOE=0, FIFOADR=00; SLRD=0 combinationally iff FLAGA=1 and RCount<RX_WORDS.
REQ-016 On each edge with SLRD=0: MEM[RCount] <= FDATA and RCount increments.
REQ-017 SHALL go RX->PROC on the edge where RCount reaches RX_WORDS; FLAGA=0 stalls RX indefinitely without error.
REQ-018 SHALL pulse proc_start high exactly one cycle, the first cycle of PROC.
REQ-019 buf_rdata SHALL equal MEM[buf_raddr] one cycle after buf_raddr is presented, in any state.
REQ-020 res_we=1 in PROC SHALL write RES[res_waddr] <= res_wdata; res_we is ignored in other states and for res_waddr>=TX_WORDS.
REQ-021 SHALL go PROC->TX_SETUP on proc_done=1; a proc_done coinciding with timeout expiry counts as done.
REQ-022 SHALL, when PROC lasts PROC_TIMEOUT cycles without proc_done, set err=1 and return to IDLE without writing EP6.
REQ-023 TX_SETUP SHALL last one cycle: FIFOADR=10, SLOE=1, FDATA high-Z.
REQ-024 In TX: FIFOADR=10, FDATA driven with RES[WCount[3:0]]; SLWR=0 combinationally iff FLAGD=1 and WCount<TX_WORDS.
REQ-025 On each edge with SLWR=0, WCount SHALL increment; FLAGD=0 stalls TX with FDATA held.
REQ-026 SHALL go TX->COMMIT when WCount reaches TX_WORDS; COMMIT->IDLE after one cycle.
REQ-027 FDATA SHALL be high-Z in every state other than TX; SLOE SHALL be 1 outside RX.
REQ-028 RCount and WCount SHALL clear on entry to IDLE; the RES contents persist across transactions.
REQ-029 SLRD and SLWR SHALL never be low in the same cycle.

Reset
REQ-030 rst=1 at any edge, including mid-RX/TX, SHALL force: state IDLE, RCount=WCount=0, err=0, SLRD=SLWR=SLOE=PKTEND=1, FIFOADR=00, proc_start=0, FDATA high-Z.
REQ-031 MEM/RES contents SHALL NOT be reset.

Configuration
REQ-032 With FX2_PKTEND_EN defined, PKTEND SHALL be 0 during COMMIT (one cycle) if FLAGD=1; if FLAGD=0, COMMIT SHALL hold until FLAGD=1.
REQ-033 Without FX2_PKTEND_EN, PKTEND SHALL be constant 1 and COMMIT SHALL last exactly one cycle.

Verification
REQ-034 FLAGA=1 for 18 words 0x0001..0x0012 -> 18 SLRD-low cycles, MEM[0..17]=0x0001..0x0012, state reaches PROC, proc_start one pulse.
REQ-035 FLAGA toggled 0/1 every cycle in RX -> SLRD low only when FLAGA=1, RCount=18 after 36 cycles, no word lost or duplicated.
REQ-036 Write RES[0..3]=0xA0..0xA3, proc_done -> one TX_SETUP cycle, then FDATA 0xA0..0xA3 on 4 SLWR-low edges, WCount=4; with FX2_PKTEND_EN, one PKTEND-low cycle.
REQ-037 FLAGD=0 for 5 cycles after the 2nd TX word -> SLWR stays 1, FDATA holds 0xA2, transfer resumes; total 4 writes.
REQ-038 No proc_done, PROC_TIMEOUT=8 -> err=1 after 8 PROC cycles, return to IDLE, SLWR never low.
REQ-039 rst=1 at RCount=7 -> next cycle state IDLE, counters 0, all strobes 1, FDATA high-Z.
